// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Accepts one event per cycle
//               from decode while idle (exception > timer interrupt > mret).
//               For traps it saves mepc/mcause/mstatus in SAVE and then
//               redirects fetch to mtvec in REDIRECT. For mret it restores
//               mstatus and redirects fetch to mepc in a single RET cycle.
//               Fetch/decode are stalled while an event is accepted or being
//               sequenced.
//
// Ports       : clk            rising-edge clock
//               rst            synchronous active-high reset
//               exc_valid      synchronous exception request from decode
//               exc_cause[3:0] exception code accompanying exc_valid
//               cur_pc[31:0]   PC of the instruction in decode
//               mret_valid     mret in decode
//               timer_irq      level-sensitive machine timer interrupt
//               csr_mstatus    current mstatus
//               csr_mtvec      current mtvec
//               csr_mepc       current mepc
//               mepc_we / mepc_wdata       mepc write port
//               mcause_we / mcause_wdata   mcause write port
//               mstatus_we / mstatus_wdata mstatus write port
//               redirect_valid / redirect_pc  fetch redirect
//               stall          hold fetch/decode
//
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] cur_pc,
    input  logic        mret_valid,
    input  logic        timer_irq,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        mepc_we,
    output logic        mcause_we,
    output logic        mstatus_we,
    output logic [31:0] mepc_wdata,
    output logic [31:0] mcause_wdata,
    output logic [31:0] mstatus_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_SAVE      = 2'd1;
    localparam logic [1:0]  c_REDIRECT  = 2'd2;
    localparam logic [1:0]  c_RET       = 2'd3;

    localparam logic [31:0] c_IRQ_CAUSE = 32'h8000_0007;
    // Offset of the timer-interrupt slot in a vectored table (4 * cause 7)
    localparam logic [31:0] c_VEC_OFFS  = 32'd28;
    localparam logic [3:0]  c_TIMER_ID  = 4'd7;

    // mstatus bit positions
    localparam int          c_MIE       = 3;
    localparam int          c_MPIE      = 7;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_cause;
    logic [31:0] r_pc;
    logic        r_is_irq;

    // ------------------------------------------------------------------------
    // Event qualification (only meaningful in IDLE)
    // ------------------------------------------------------------------------
    logic w_idle;
    logic w_irq_pending;
    logic w_take_exc;
    logic w_take_irq;
    logic w_take_mret;

    assign w_idle        = (r_state == c_IDLE);
    assign w_irq_pending = timer_irq & csr_mstatus[c_MIE];
    assign w_take_exc    = w_idle & exc_valid;
    assign w_take_irq    = w_idle & ~exc_valid & w_irq_pending;
    assign w_take_mret   = w_idle & ~exc_valid & ~w_irq_pending & mret_valid;

    // Low bits of mepc are ignored on return; keep them visibly consumed.
    logic w_unused;
    assign w_unused = ^csr_mepc[1:0];

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cause  <= 4'd0;
            r_pc     <= 32'd0;
            r_is_irq <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_take_exc) begin
                        r_cause  <= exc_cause;
                        r_pc     <= cur_pc;
                        r_is_irq <= 1'b0;
                        r_state  <= c_SAVE;
                    end else if (w_take_irq) begin
                        r_cause  <= c_TIMER_ID;
                        r_pc     <= cur_pc;
                        r_is_irq <= 1'b1;
                        r_state  <= c_SAVE;
                    end else if (w_take_mret) begin
                        r_state  <= c_RET;
                    end
                end
                c_SAVE:     r_state <= c_REDIRECT;
                c_REDIRECT: r_state <= c_IDLE;
                c_RET:      r_state <= c_IDLE;
                default:    r_state <= c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Write data / redirect target computation
    // ------------------------------------------------------------------------
    logic [31:0] w_trap_mstatus;
    logic [31:0] w_ret_mstatus;
    logic [31:0] w_tvec_base;
    logic [31:0] w_trap_target;

    always_comb begin
        // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
        w_trap_mstatus          = csr_mstatus;
        w_trap_mstatus[c_MPIE]  = csr_mstatus[c_MIE];
        w_trap_mstatus[c_MIE]   = 1'b0;
        w_trap_mstatus[12:11]   = 2'b11;

        // Return: MIE <- MPIE, MPIE <- 1, MPP stays M (M-only core)
        w_ret_mstatus           = csr_mstatus;
        w_ret_mstatus[c_MIE]    = csr_mstatus[c_MPIE];
        w_ret_mstatus[c_MPIE]   = 1'b1;
        w_ret_mstatus[12:11]    = 2'b11;
    end

    assign w_tvec_base   = {csr_mtvec[31:2], 2'b00};
    // Vectored mode only relocates interrupts; the add wraps naturally.
    assign w_trap_target = ((csr_mtvec[1:0] == 2'b01) && r_is_irq)
                         ? (w_tvec_base + c_VEC_OFFS)
                         : w_tvec_base;

    // ------------------------------------------------------------------------
    // Outputs: decoded from state; everything forced low while in reset so
    // nothing leaks out of an aborted sequence.
    // ------------------------------------------------------------------------
    always_comb begin
        mepc_we        = 1'b0;
        mcause_we      = 1'b0;
        mstatus_we     = 1'b0;
        mepc_wdata     = 32'd0;
        mcause_wdata   = 32'd0;
        mstatus_wdata  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;

        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    stall = w_take_exc | w_take_irq | w_take_mret;
                end
                c_SAVE: begin
                    stall         = 1'b1;
                    mepc_we       = 1'b1;
                    mcause_we     = 1'b1;
                    mstatus_we    = 1'b1;
                    mepc_wdata    = {r_pc[31:2], 2'b00};
                    mcause_wdata  = r_is_irq ? c_IRQ_CAUSE : {28'd0, r_cause};
                    mstatus_wdata = w_trap_mstatus;
                end
                c_REDIRECT: begin
                    stall          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = w_trap_target;
                end
                c_RET: begin
                    stall          = 1'b1;
                    mstatus_we     = 1'b1;
                    mstatus_wdata  = w_ret_mstatus;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_mepc[31:2], 2'b00};
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Self-checking bench for trap_ctrl. Each scenario task drives
//               a cycle-by-cycle stimulus list, pushes the expected output
//               snapshot for that cycle onto a scoreboard queue, and pops and
//               compares it against the sampled DUT outputs mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] cur_pc;
    logic        mret_valid;
    logic        timer_irq;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        mepc_we;
    logic        mcause_we;
    logic        mstatus_we;
    logic [31:0] mepc_wdata;
    logic [31:0] mcause_wdata;
    logic [31:0] mstatus_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .cur_pc         (cur_pc),
        .mret_valid     (mret_valid),
        .timer_irq      (timer_irq),
        .csr_mstatus    (csr_mstatus),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .mepc_we        (mepc_we),
        .mcause_we      (mcause_we),
        .mstatus_we     (mstatus_we),
        .mepc_wdata     (mepc_wdata),
        .mcause_wdata   (mcause_wdata),
        .mstatus_wdata  (mstatus_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable output snapshot; data fields only count when their strobe
    // is high.
    typedef struct packed {
        logic        mepc_we;
        logic        mcause_we;
        logic        mstatus_we;
        logic [31:0] mepc_wd;
        logic [31:0] mcause_wd;
        logic [31:0] mstatus_wd;
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic        mret;
        logic        irq;
        logic [31:0] ms;
        logic [31:0] tv;
        logic [31:0] ep;
    } stim_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------------------------------------------------------- helpers
    function automatic stim_t mk_s(logic r, logic e, logic [3:0] c, logic [31:0] pc,
                                   logic m, logic i, logic [31:0] ms,
                                   logic [31:0] tv, logic [31:0] ep);
        stim_t s;
        s.rst = r; s.exc = e; s.cause = c; s.pc = pc; s.mret = m; s.irq = i;
        s.ms = ms; s.tv = tv; s.ep = ep;
        return s;
    endfunction

    function automatic obs_t e_none();
        obs_t o = '0;
        return o;
    endfunction

    function automatic obs_t e_busy();
        obs_t o = '0;
        o.stall = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_save(logic [31:0] mepc, logic [31:0] mcause, logic [31:0] ms);
        obs_t o = '0;
        o.mepc_we = 1'b1; o.mcause_we = 1'b1; o.mstatus_we = 1'b1;
        o.mepc_wd = mepc; o.mcause_wd = mcause; o.mstatus_wd = ms;
        o.stall = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_redir(logic [31:0] pc);
        obs_t o = '0;
        o.rv = 1'b1; o.rpc = pc; o.stall = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_ret(logic [31:0] ms, logic [31:0] pc);
        obs_t o = '0;
        o.mstatus_we = 1'b1; o.mstatus_wd = ms;
        o.rv = 1'b1; o.rpc = pc; o.stall = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.mepc_we    = mepc_we;
        o.mcause_we  = mcause_we;
        o.mstatus_we = mstatus_we;
        o.mepc_wd    = mepc_we    ? mepc_wdata    : 32'd0;
        o.mcause_wd  = mcause_we  ? mcause_wdata  : 32'd0;
        o.mstatus_wd = mstatus_we ? mstatus_wdata : 32'd0;
        o.rv         = redirect_valid;
        o.rpc        = redirect_valid ? redirect_pc : 32'd0;
        o.stall      = stall;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        rst         = s.rst;
        exc_valid   = s.exc;
        exc_cause   = s.cause;
        cur_pc      = s.pc;
        mret_valid  = s.mret;
        timer_irq   = s.irq;
        csr_mstatus = s.ms;
        csr_mtvec   = s.tv;
        csr_mepc    = s.ep;
    endtask

    // -------------------------------------------------------------- scenarios
    task automatic test_reset();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        // events presented during reset must not show up anywhere
        s.push_back(mk_s(1, 1, 4'd11, 32'h8000_0010, 1, 1, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(1, 0, 4'd0,  32'h0,         0, 1, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exception();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        // ecall
        s.push_back(mk_s(0, 1, 4'd11, 32'h8000_0010, 0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_save(32'h8000_0010, 32'hB, 32'h1880));
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_redir(32'h8000_0100));
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        // illegal instr, unaligned PC, vectored mtvec (exceptions use base)
        s.push_back(mk_s(0, 1, 4'd2,  32'h8000_0013, 0, 0, 32'h0, 32'h8000_0201, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h0, 32'h8000_0201, 32'h0)); e.push_back(e_save(32'h8000_0010, 32'h2, 32'h1800));
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h0, 32'h8000_0201, 32'h0)); e.push_back(e_redir(32'h8000_0200));
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h0, 32'h8000_0201, 32'h0)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL exception[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_interrupt();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        // vectored timer interrupt; irq held high while sequencing is ignored
        s.push_back(mk_s(0, 0, 4'd0, 32'h0000_1236, 0, 1, 32'h8, 32'h8000_0201, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 1, 32'h8, 32'h8000_0201, 32'h0)); e.push_back(e_save(32'h0000_1234, 32'h8000_0007, 32'h1880));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 1, 32'h8, 32'h8000_0201, 32'h0)); e.push_back(e_redir(32'h8000_021C));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0201, 32'h0)); e.push_back(e_none());
        // vectored target wraps past 2^32; mstatus with all other bits set
        s.push_back(mk_s(0, 0, 4'd0, 32'h4000_0000, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0)); e.push_back(e_save(32'h4000_0000, 32'h8000_0007, 32'hFFFF_FFF7));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0)); e.push_back(e_redir(32'h0000_000C));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0)); e.push_back(e_none());
        // masked: MIE=0 -> nothing happens for several cycles
        s.push_back(mk_s(0, 0, 4'd0, 32'h100,       0, 1, 32'h1880, 32'h8000_0201, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(0, 0, 4'd0, 32'h100,       0, 1, 32'h1880, 32'h8000_0201, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(0, 0, 4'd0, 32'h100,       0, 1, 32'h1880, 32'h8000_0201, 32'h0)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL interrupt[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        // all three at once -> exception wins (non-vectored target)
        s.push_back(mk_s(0, 1, 4'd3, 32'h0000_0100, 1, 1, 32'h8, 32'h8000_0201, 32'h8000_0040)); e.push_back(e_busy());
        s.push_back(mk_s(0, 1, 4'd3, 32'h0000_0100, 1, 1, 32'h8, 32'h8000_0201, 32'h8000_0040)); e.push_back(e_save(32'h0000_0100, 32'h3, 32'h1880));
        s.push_back(mk_s(0, 1, 4'd3, 32'h0000_0100, 1, 1, 32'h8, 32'h8000_0201, 32'h8000_0040)); e.push_back(e_redir(32'h8000_0200));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0201, 32'h8000_0040)); e.push_back(e_none());
        // interrupt beats mret; direct-mode mtvec
        s.push_back(mk_s(0, 0, 4'd0, 32'h0000_0200, 1, 1, 32'h8, 32'h8000_0100, 32'h8000_0040)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h8000_0040)); e.push_back(e_save(32'h0000_0200, 32'h8000_0007, 32'h1880));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h8000_0040)); e.push_back(e_redir(32'h8000_0100));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h8000_0040)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL priority[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mret();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk_s(0, 0, 4'd0, 32'h0, 1, 0, 32'h1880, 32'h8000_0100, 32'h8000_0014)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0, 32'h0, 0, 0, 32'h1880, 32'h8000_0100, 32'h8000_0014)); e.push_back(e_ret(32'h1888, 32'h8000_0014));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0, 0, 0, 32'h1880, 32'h8000_0100, 32'h8000_0014)); e.push_back(e_none());
        // MPIE=0 restores MIE=0; unaligned mepc is truncated
        s.push_back(mk_s(0, 0, 4'd0, 32'h0, 1, 0, 32'h1808, 32'h8000_0100, 32'h8000_0017)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0, 32'h0, 0, 0, 32'h1808, 32'h8000_0100, 32'h8000_0017)); e.push_back(e_ret(32'h1880, 32'h8000_0014));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0, 0, 0, 32'h1808, 32'h8000_0100, 32'h8000_0017)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL mret[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        s.push_back(mk_s(0, 1, 4'd11, 32'h8000_0010, 0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(1, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        s.push_back(mk_s(0, 1, 4'd11, 32'h8000_0020, 0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_save(32'h8000_0020, 32'hB, 32'h1880));
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_redir(32'h8000_0100));
        // reset in RET also aborts the return
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         1, 0, 32'h1880, 32'h8000_0100, 32'h8000_0014)); e.push_back(e_busy());
        s.push_back(mk_s(1, 0, 4'd0,  32'h0,         0, 0, 32'h1880, 32'h8000_0100, 32'h8000_0014)); e.push_back(e_none());
        s.push_back(mk_s(0, 0, 4'd0,  32'h0,         0, 0, 32'h1880, 32'h8000_0100, 32'h8000_0014)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$]; obs_t e[$]; obs_t got, want;
        // exception held by stalled upstream: re-accepted only back in IDLE
        s.push_back(mk_s(0, 1, 4'd8, 32'h0000_0400, 0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 1, 4'd8, 32'h0000_0400, 0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_save(32'h0000_0400, 32'h8, 32'h1880));
        s.push_back(mk_s(0, 1, 4'd8, 32'h0000_0400, 1, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_redir(32'h8000_0100));
        s.push_back(mk_s(0, 1, 4'd9, 32'h0000_0800, 0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_busy());
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         1, 1, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_save(32'h0000_0800, 32'h9, 32'h1880));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_redir(32'h8000_0100));
        s.push_back(mk_s(0, 0, 4'd0, 32'h0,         0, 0, 32'h8, 32'h8000_0100, 32'h0)); e.push_back(e_none());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        rst = 1'b1; exc_valid = 1'b0; exc_cause = 4'd0; cur_pc = 32'd0;
        mret_valid = 1'b0; timer_irq = 1'b0; csr_mstatus = 32'd0;
        csr_mtvec = 32'd0; csr_mepc = 32'd0;
        @(posedge clk); #1;

        test_reset();
        test_exception();
        test_interrupt();
        test_priority();
        test_mret();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port: exc_valid  input  1  synchronous exception request (ecall, illegal instr) from decode.
REQ-004 SHALL have port: exc_cause  input  4  exception code accompanying exc_valid.
REQ-005 SHALL have port: cur_pc  input  32  PC of the instruction currently in decode.
REQ-006 SHALL have port: mret_valid  input  1  mret instruction in decode.
REQ-007 SHALL have port: timer_irq  input  1  level-sensitive machine timer interrupt.
REQ-008 SHALL have ports: csr_mstatus, csr_mtvec, csr_mepc  input  32 each  current CSR contents.
REQ-009 SHALL have ports: mepc_we, mcause_we, mstatus_we  output  1 each  CSR write strobes.
REQ-010 SHALL have ports: mepc_wdata, mcause_wdata, mstatus_wdata  output  32 each  CSR write data.
REQ-011 SHALL have ports: redirect_valid  output  1; redirect_pc  output  32  PC redirect to fetch.
REQ-012 SHALL have port: stall  output  1  holds fetch/decode while a trap or return is sequenced.

Function
REQ-013 SHALL implement FSM states IDLE, SAVE, REDIRECT, RET.
REQ-014 In IDLE, SHALL accept at most one event per cycle, priority exc_valid > interrupt > mret_valid.
REQ-015 Interrupt SHALL be taken only when timer_irq=1 and csr_mstatus[3] (MIE)=1.
REQ-016 Exception or interrupt accepted at cycle N: SHALL latch cause and cur_pc, enter SAVE at N+1.
REQ-017 In SAVE (one cycle), SHALL assert mepc_we, mcause_we and mstatus_we for exactly one cycle.
REQ-018 SAVE write data: mepc_wdata = latched PC with bits[1:0] forced to 0.
REQ-019 SAVE write data: mcause_wdata = {28'b0, cause} for exceptions, or 32'h8000_0007 for the timer interrupt.
REQ-020 SAVE write data: mstatus_wdata = csr_mstatus with MPIE[7] set to the old MIE, MIE[3]=0, and MPP[12:11]=2'b11.
REQ-021 In REDIRECT (one cycle), SHALL assert redirect_valid, then return to IDLE.
REQ-022 redirect_pc base SHALL be {csr_mtvec[31:2],2'b00}.
REQ-023 If csr_mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc SHALL be base + 4*7; the addition wraps modulo 2^32.
REQ-024 mret accepted at cycle N: SHALL enter RET at N+1.
REQ-025 In RET, SHALL assert mstatus_we with MIE=old MPIE, MPIE=1, MPP=2'b11.
REQ-026 In RET, SHALL also assert redirect_valid with redirect_pc = {csr_mepc[31:2],2'b00}, then return to IDLE.
REQ-027 stall SHALL be 1 combinationally in the cycle an event is accepted and in every non-IDLE state; otherwise 0.
REQ-028 Inputs arriving while not in IDLE SHALL be ignored; upstream re-presents them because of stall.
REQ-029 All write strobes and redirect_valid SHALL be 0 in any state not listed above.
REQ-030 Interrupt latency: exception taken IDLE->SAVE->REDIRECT, 3 cycles including the accept cycle; mret takes 2 cycles.

Reset
REQ-031 On rst=1 at a clk edge, FSM SHALL go to IDLE and latched cause/PC SHALL clear to 0.
REQ-032 Reset applied mid-sequence (SAVE, REDIRECT or RET) SHALL abort the sequence with no further strobes.
REQ-033 While rst=1, all outputs SHALL be 0, including stall.

Verification
REQ-034 Ecall: exc_valid=1, exc_cause=11, cur_pc=0x8000_0010, mtvec=0x8000_0100 -> next cycle mepc_wdata=0x8000_0010, mcause_wdata=0xB; following cycle redirect_pc=0x8000_0100.
REQ-035 Vectored interrupt: timer_irq=1, mstatus=0x0000_0008, mtvec=0x8000_0201 -> mcause_wdata=0x8000_0007, mstatus_wdata=0x0000_1880, redirect_pc=0x8000_021C.
REQ-036 Masked interrupt: timer_irq=1, mstatus[3]=0 -> no strobes, stall=0, FSM remains IDLE.
REQ-037 Simultaneous events: exc_valid, timer_irq (MIE=1) and mret_valid all 1 -> exception path taken with mcause_wdata=exc_cause.
REQ-038 mret: mstatus=0x0000_1880, mepc=0x8000_0014 -> next cycle mstatus_wdata=0x0000_1888, redirect_pc=0x8000_0014.
REQ-039 Reset during SAVE -> next cycle all outputs 0, and a new ecall is accepted normally afterward.
